// File: rtl/rtc_bus_arbiter.sv
// Round-robin owner of the shared RTC bus: grants one engine at a time, forwards its
// bus signals with one cycle of latency, and aborts engines that never ack or that hang.
module rtc_bus_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned ACK_WAIT = 4,
    parameter int unsigned TIMEOUT  = 1023,
    parameter int unsigned GUARD    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   busy,
    input  logic [NREQ-1:0]   eng_ad,
    input  logic [NREQ-1:0]   eng_wr,
    input  logic [NREQ-1:0]   eng_rd,
    input  logic [NREQ-1:0]   eng_cs,
    input  logic [8*NREQ-1:0] eng_dout,
    output logic [NREQ-1:0]   start,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        ADout,
    output logic              ad,
    output logic              wr,
    output logic              rd,
    output logic              cs,
    output logic              abort
);

    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);
    localparam int unsigned AW  = $clog2(ACK_WAIT + 1);
    localparam int unsigned GW  = $clog2(GUARD + 1);
    localparam int unsigned CW1 = (TW > AW) ? TW : AW;
    localparam int unsigned CW  = (CW1 > GW) ? CW1 : GW;

    typedef enum logic [1:0] {StIdle, StAck, StRun, StGuard} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] start_q, start_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic            abort_q, abort_d;
    logic [7:0]      dout_q, dout_d;
    logic            ad_q, ad_d, wr_q, wr_d, rd_q, rd_d, cs_q, cs_d;

    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   nxt_ptr;
    logic            own;

    // First requester at or above the pointer, wrapping.
    always_comb begin
        int unsigned e;
        e     = 0;
        found = 1'b0;
        pick  = ptr_q;
        for (int unsigned k = 0; k < NREQ; k++) begin
            e = (32'(ptr_q) + k) % NREQ;
            if (!found && req[e]) begin
                found = 1'b1;
                pick  = IW'(e);
            end
        end
    end

    assign nxt_ptr = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        start_d = '0;
        grant_d = grant_q;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d       = StAck;
                    idx_d         = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    start_d       = '0;
                    start_d[pick] = 1'b1;
                    cnt_d         = '0;
                end
            end
            StAck: begin
                if (busy[idx_q]) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(ACK_WAIT - 1)) begin
                    abort_d = 1'b1;
                    state_d = StGuard;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!busy[idx_q] || cnt_q == CW'(TIMEOUT - 1)) begin
                    abort_d = busy[idx_q];
                    state_d = StGuard;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGuard: begin
                if (cnt_q == CW'(GUARD - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Forward the owner's pins only while it keeps the bus into the next cycle.
    assign own = (state_q == StAck || state_q == StRun) &&
                 (state_d == StAck || state_d == StRun);

    always_comb begin
        dout_d = 8'hFF;
        ad_d   = 1'b1;
        wr_d   = 1'b1;
        rd_d   = 1'b1;
        cs_d   = 1'b1;
        if (own) begin
            dout_d = eng_dout[{idx_q, 3'b000} +: 8];
            ad_d   = eng_ad[idx_q];
            wr_d   = eng_wr[idx_q];
            rd_d   = eng_rd[idx_q];
            cs_d   = eng_cs[idx_q];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            start_q <= '0;
            grant_q <= '0;
            abort_q <= 1'b0;
            dout_q  <= 8'hFF;
            ad_q    <= 1'b1;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            grant_q <= grant_d;
            abort_q <= abort_d;
            dout_q  <= dout_d;
            ad_q    <= ad_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cs_q    <= cs_d;
        end
    end

    assign start = start_q;
    assign grant = grant_q;
    assign abort = abort_q;
    assign ADout = dout_q;
    assign ad    = ad_q;
    assign wr    = wr_q;
    assign rd    = rd_q;
    assign cs    = cs_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Randomized bench for rtc_bus_arbiter: engines are modelled in the stimulus process, the
// expected grant order comes from a round-robin model, and a monitor scores every cycle.
module tb_rtc_bus_arbiter;

    localparam int N        = 3;
    localparam int ACK_WAIT = 4;
    localparam int TIMEOUT  = 1023;
    localparam int GUARD    = 4;
    localparam int MNORM    = 0;
    localparam int MNOACK   = 1;
    localparam int MHANG    = 2;
    localparam int MRAND    = 3;
    localparam int NEVER    = 32'h3fffffff;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0, busy = '0;
    logic [N-1:0]   e_ad = '1, e_wr = '1, e_rd = '1, e_cs = '1;
    logic [8*N-1:0] e_dout = '1;
    logic [N-1:0]   start, grant;
    logic [7:0]     ADout;
    logic           ad, wr, rd, cs, abort;

    rtc_bus_arbiter #(.NREQ(N), .ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
        .clock(clock), .reset(reset), .req(req), .busy(busy),
        .eng_ad(e_ad), .eng_wr(e_wr), .eng_rd(e_rd), .eng_cs(e_cs), .eng_dout(e_dout),
        .start(start), .grant(grant), .ADout(ADout), .ad(ad), .wr(wr), .rd(rd), .cs(cs),
        .abort(abort)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int eng; int mode; bit chained;} exp_t;
    exp_t sbq[$];

    int checks = 0;
    int errors = 0;

    int mode_of[N];
    int len_of[N];
    int dly_of[N];
    int own_end = NEVER;
    int cur = -1;
    int model_ptr = 0;
    int ghost = 0;
    int ghost_cnt = 0;
    bit mon_en = 1'b0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endfunction

    // ---------------- monitor ----------------
    bit          active = 1'b0;
    bit          prev_owned = 1'b0;
    bit          owned;
    int          own_start = 0, owner = 0, omode = 0;
    logic [11:0] prev_bus = '1;
    logic [11:0] exp_pins;
    logic [N-1:0] exp_grant;
    exp_t        mon_e;

    always @(negedge clock) begin
        if (!reset || !mon_en) begin
            active     = 1'b0;
            prev_owned = 1'b0;
        end else begin
            owned = active && cyc >= own_start && cyc <= own_end;
            if (start != '0) begin
                if (sbq.size() == 0) begin
                    check("unexpected_start", 32'(start), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("start_onehot", 32'(start), 32'(1) << mon_e.eng);
                    if (active) begin
                        if (mon_e.chained) check("guard_gap", cyc - own_end, GUARD + 2);
                        else check("guard_min", 32'(cyc - own_end >= GUARD + 2), 32'd1);
                    end
                    active    = 1'b1;
                    own_start = cyc;
                    owner     = mon_e.eng;
                    omode     = mon_e.mode;
                    own_end   = (mon_e.mode == MNOACK) ? cyc + ACK_WAIT - 1 : NEVER;
                    owned     = 1'b1;
                end
            end
            exp_grant = owned ? N'(1) << owner : '0;
            check("grant", 32'(grant), 32'(exp_grant));
            exp_pins = (prev_owned && owned) ? prev_bus : 12'hFFF;
            check("bus_pins", 32'({ADout, ad, wr, rd, cs}), 32'(exp_pins));
            check("abort", 32'(abort),
                  32'(active && omode != MNORM && cyc == own_end + 1));
            prev_owned = owned;
            prev_bus   = {e_dout[owner*8 +: 8], e_ad[owner], e_wr[owner], e_rd[owner],
                          e_cs[owner]};
        end
    end

    // ---------------- stimulus / engine models ----------------
    task automatic lines(input int i, input bit rnd);
        e_dout[i*8 +: 8] = rnd ? 8'($urandom) : 8'hFF;
        e_ad[i] = rnd ? 1'($urandom) : 1'b1;
        e_wr[i] = rnd ? 1'($urandom) : 1'b1;
        e_rd[i] = rnd ? 1'($urandom) : 1'b1;
        e_cs[i] = rnd ? 1'($urandom) : 1'b1;
    endtask

    // Advance one cycle; non-owning engines put garbage on their bus inputs.
    task automatic tick();
        @(posedge clock);
        #1;
        for (int j = 0; j < N; j++) if (j != cur) lines(j, 1'b1);
        if (ghost_cnt > 0) begin
            ghost_cnt--;
            if (ghost_cnt == 0) req[ghost] = 1'b0;
        end
    endtask

    task automatic serve(input int i);
        int b;
        cur    = i;
        req[i] = 1'b0;
        lines(i, 1'b0);
        if (mode_of[i] == MNORM) begin
            repeat (dly_of[i] + 1) tick();
            busy[i] = 1'b1;
            lines(i, 1'b1);
            repeat (len_of[i] - 1) begin
                tick();
                lines(i, 1'b1);
            end
            tick();
            busy[i] = 1'b0;
            lines(i, 1'b0);
            own_end = cyc;
        end else if (mode_of[i] == MNOACK) begin
            b = 0;
            while (!abort && b < 20) begin tick(); b++; end
            if (!abort) begin
                checks++; errors++;
                $display("FAIL noack_abort_wait engine %0d: no abort seen, wanted one", i);
            end
        end else begin
            tick();
            busy[i] = 1'b1;
            lines(i, 1'b1);
            own_end = cyc + TIMEOUT;
            b = 0;
            do begin tick(); lines(i, 1'b1); b++; end while (!abort && b < TIMEOUT + 20);
            if (!abort) begin
                checks++; errors++;
                $display("FAIL hang_abort_wait engine %0d: no abort seen, wanted one", i);
            end
            busy[i] = 1'b0;
            lines(i, 1'b0);
        end
        cur = -1;
    endtask

    // fm holds a 2-bit mode per engine; MRAND picks one at random.
    task automatic run_round(input logic [N-1:0] set, input logic [2*N-1:0] fm);
        int   cnt, last, b, idx, r;
        bit   first, do_ghost;
        logic [N-1:0] free;
        cnt = 0; first = 1'b1; last = 0;
        for (int e = 0; e < N; e++) begin
            mode_of[e] = int'(fm[2*e +: 2]);
            if (mode_of[e] == MRAND) begin
                r = $urandom_range(0, 99);
                mode_of[e] = (r < 3) ? MHANG : (r < 18) ? MNOACK : MNORM;
            end
            dly_of[e] = $urandom_range(0, ACK_WAIT - 2);
            len_of[e] = $urandom_range(2, 40);
        end
        for (int k = 0; k < N; k++) begin
            int e;
            e = (model_ptr + k) % N;
            if (set[e]) begin
                sbq.push_back('{eng: e, mode: mode_of[e], chained: !first});
                first = 1'b0;
                last  = e;
                cnt++;
            end
        end
        model_ptr = (last + 1) % N;
        free      = ~set;
        do_ghost  = (free != '0) && ($urandom_range(0, 1) == 1);
        req       = req | set;
        for (int n = 0; n < cnt; n++) begin
            b = 0;
            while (start == '0 && b < 4000) begin tick(); b++; end
            if (start == '0) begin
                checks++; errors++;
                $display("FAIL start_wait: start=0 after %0d cycles, wanted a grant", b);
                return;
            end
            idx = 0;
            for (int j = 0; j < N; j++) if (start[j]) idx = j;
            if (n == 0 && do_ghost) begin
                for (int j = 0; j < N; j++) if (free[j]) ghost = j;
                req[ghost] = 1'b1;
                ghost_cnt  = 4;
            end
            serve(idx);
        end
    endtask

    initial begin
        // Reset held with random inputs: pins must stay idle.
        for (int k = 0; k < 6; k++) begin
            @(posedge clock);
            #1;
            req  = N'($urandom);
            busy = N'($urandom);
            for (int j = 0; j < N; j++) lines(j, 1'b1);
            #3;
            check("rst_bus", 32'({ADout, ad, wr, rd, cs}), 32'hFFF);
            check("rst_ctrl", 32'({start, grant, abort}), 32'd0);
        end
        req  = '0;
        busy = '0;
        tick();
        reset  = 1'b1;
        mon_en = 1'b1;

        run_round(3'b010, {2'd0, 2'd0, 2'd0});
        run_round(3'b111, {2'd0, 2'd0, 2'd0});
        run_round(3'b111, {2'd0, 2'd0, 2'd0});
        run_round(3'b100, {2'd1, 2'd1, 2'd1});
        run_round(3'b011, {2'd3, 2'd0, 2'd2});
        for (int r = 0; r < 30; r++) run_round(N'($urandom_range(1, 7)), '1);

        // Reset while engine 1 is in its data phase.
        run_round_until_data();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_bus", 32'({ADout, ad, wr, rd, cs}), 32'hFFF);
        check("midrst_ctrl", 32'({start, grant, abort}), 32'd0);
        busy = '0;
        lines(1, 1'b0);
        cur = -1;
        sbq.delete();
        model_ptr = 0;
        tick();
        tick();
        reset = 1'b1;
        run_round(3'b011, {2'd0, 2'd0, 2'd0});

        repeat (GUARD + 4) tick();
        check("queue_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic run_round_until_data();
        int b;
        sbq.push_back('{eng: 1, mode: MNORM, chained: 1'b0});
        model_ptr = 2;
        req[1] = 1'b1;
        b = 0;
        while (start == '0 && b < 100) begin tick(); b++; end
        if (start != 3'b010) begin
            checks++; errors++;
            $display("FAIL midrst_start: start=%0b, wanted 010", start);
        end
        cur     = 1;
        req[1]  = 1'b0;
        lines(1, 1'b0);
        tick();
        busy[1] = 1'b1;
        e_dout[15:8] = 8'h5A;
        e_wr[1] = 1'b0;
        e_cs[1] = 1'b0;
        tick();
        tick();
        check("midrst_pre_wr", 32'({wr, cs, ADout}), 32'h05A);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
